// File: rtl/aes128_pkg.sv
// AES-128 shared definitions: S-box, round constants and the
// byte-level round transforms used by every pipeline stage.
package aes128_pkg;

    typedef logic [127:0] blk_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcolumn(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]],
                SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic blk_t subbytes(input blk_t s);
        blk_t o;
        for (int i = 0; i < 4; i++)
            o[32*i +: 32] = subword(s[32*i +: 32]);
        return o;
    endfunction

    // Byte i of the block is row i%4, column i/4; row r rotates left by r.
    function automatic blk_t shiftrows(input blk_t s);
        blk_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic blk_t mixcolumns(input blk_t s);
        blk_t o;
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = mixcolumn(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic blk_t keyexp(input blk_t k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = subword({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes128_round.sv
// One AES round as two register stages plus the matching key step.
// Ports: clk, rst, s_i/k_i (previous state/key), pass_i, s_o/k_o.
module aes128_round
    import aes128_pkg::*;
#(
    parameter int ROUND = 1,
    parameter bit FINAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] s_i,
    input  logic [127:0] k_i,
    input  logic         pass_i,
    output logic [127:0] s_o,
    output logic [127:0] k_o
);

    blk_t sb_q, sb_d;
    blk_t ka_q, ka_d;
    blk_t s_q, s_d;
    blk_t kb_q, kb_d;
    blk_t sr;
    blk_t mx;

    always_comb begin
        sb_d = subbytes(s_i);
        ka_d = keyexp(k_i, RCON[ROUND-1]);
        sr   = shiftrows(sb_q);
        mx   = FINAL ? sr : mixcolumns(sr);
        // pass_i blanks slots that carry no real block (post-reset fill).
        s_d  = pass_i ? (mx ^ ka_q) : '0;
        // Delay the round key so it stays aligned with its block.
        kb_d = ka_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
            ka_q <= '0;
            s_q  <= '0;
            kb_q <= '0;
        end else begin
            sb_q <= sb_d;
            ka_q <= ka_d;
            s_q  <= s_d;
            kb_q <= kb_d;
        end
    end

    assign s_o = s_q;
    assign k_o = kb_q;

endmodule

// File: rtl/aes128.sv
// Fully pipelined AES-128 encryptor, 1 block/clk, latency 20 edges.
// Ports: clk, rst, state, key, out; AES128_VALID_EN adds in_valid/out_valid.
module aes128
    import aes128_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] state,
    input  logic [127:0] key,
`ifdef AES128_VALID_EN
    input  logic         in_valid,
    output logic         out_valid,
`endif
    output logic [127:0] out
);

    blk_t        s0_q, s0_d;
    blk_t        k0_q, k0_d;
    logic [19:0] live_q, live_d;
    blk_t        state_w [11];
    blk_t        key_w [11];
    blk_t        key_unused;

    // live_q tracks which stages hold a block captured after reset,
    // so the reset zeros are never pushed through the rounds to out.
    always_comb begin
        s0_d   = state ^ key;
        k0_d   = key;
        live_d = {live_q[18:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q   <= '0;
            k0_q   <= '0;
            live_q <= '0;
        end else begin
            s0_q   <= s0_d;
            k0_q   <= k0_d;
            live_q <= live_d;
        end
    end

    assign state_w[0] = s0_q;
    assign key_w[0]   = k0_q;

    for (genvar r = 0; r < 10; r++) begin : g_round
        aes128_round #(
            .ROUND (r + 1),
            .FINAL (r == 9)
        ) u_round (
            .clk    (clk),
            .rst    (rst),
            .s_i    (state_w[r]),
            .k_i    (key_w[r]),
            .pass_i ((r == 9) ? live_q[19] : 1'b1),
            .s_o    (state_w[r+1]),
            .k_o    (key_w[r+1])
        );
    end

    assign out        = state_w[10];
    assign key_unused = key_w[10];

`ifdef AES128_VALID_EN
    logic [20:0] vld_q, vld_d;

    always_comb begin
        vld_d = {vld_q[19:0], in_valid};
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    assign out_valid = vld_q[20];
`endif

endmodule

// File: tb/tb_aes128.sv
// Self-checking bench for aes128: byte-array AES reference model
// with a GF(2^8)-derived S-box, directed vectors and random stream.
module tb_aes128;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] state;
    logic [127:0] key;
    logic [127:0] out;
    logic         in_valid;
`ifdef AES128_VALID_EN
    logic         out_valid;
`endif

    always #5 clk = ~clk;

    aes128 dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .key       (key),
`ifdef AES128_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .out       (out)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lastrst = -1000;

    logic [7:0]   sb [256];
    logic [127:0] exp_a [1024];
    logic [127:0] kat_a [1024];
    logic         kat_v [1024];
    logic         vin_a [1024];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic       hi;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x = x << 1;
            if (hi) x = x ^ 8'h1b;
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv, xb;
        for (int x = 0; x < 256; x++) begin
            xb = 8'(x);
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int j = 0; j < 254; j++) inv = gmul(inv, xb);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                  ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [176];
        logic [7:0] tmp [4];
        logic [7:0] rc, x;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            w[i] = k[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                x = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[x];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++)
                    t[rr+4*c] = s[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check();
        logic [127:0] e;
        logic         ev;
        logic         fresh;
        if (lastrst < 0) return;
        fresh = (cyc - lastrst) > 20;
        e  = fresh ? exp_a[cyc-20] : 128'h0;
        ev = fresh ? vin_a[cyc-20] : 1'b0;
        n_cmp++;
        assert (out === e) else begin
            n_bad++;
            $error("FAIL out cyc=%0d got=%h exp=%h", cyc, out, e);
        end
        if (fresh && kat_v[cyc-20]) begin
            n_cmp++;
            assert (out === kat_a[cyc-20]) else begin
                n_bad++;
                $error("FAIL kat cyc=%0d got=%h exp=%h", cyc, out, kat_a[cyc-20]);
            end
        end
`ifdef AES128_VALID_EN
        n_cmp++;
        assert (out_valid === ev) else begin
            n_bad++;
            $error("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ev);
        end
`else
        if (ev === 1'bx) $display("note: undefined valid history at cyc %0d", cyc);
`endif
    endtask

    task automatic drive(input logic [127:0] s, input logic [127:0] k,
                         input logic r, input logic v,
                         input logic [127:0] kat, input logic has_kat);
        int idx;
        state    = s;
        key      = k;
        rst      = r;
        in_valid = v;
        idx = cyc + 1;
        exp_a[idx] = aes_ref(s, k);
        kat_a[idx] = kat;
        kat_v[idx] = has_kat;
        vin_a[idx] = v;
        @(posedge clk);
        cyc++;
        if (r) lastrst = cyc;
        #1;
        check();
    endtask

    initial begin
        state = '0; key = '0; rst = 1'b1; in_valid = 1'b0;
        build_sbox();

        drive('0, '0, 1'b1, 1'b0, '0, 1'b0);
        drive('0, '0, 1'b1, 1'b0, '0, 1'b0);

        drive(128'h3243f6a8885a308d313198a2e0370734,
              128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1,
              128'h3925841d02dc09fbdc118597196a0b32, 1'b1);
        drive(128'h00112233445566778899aabbccddeeff,
              128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
        drive(128'h0, 128'h0, 1'b0, 1'b0,
              128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b1);
        drive(128'h0, 128'h1, 1'b0, 1'b1,
              128'h0545aad56da2a97c3663d1432a3d1c84, 1'b1);
        drive(128'h1, 128'h0, 1'b0, 1'b1,
              128'h58e2fccefa7e3061367f1d57a4e7455a, 1'b1);

        for (int i = 0; i < 40; i++)
            drive(rnd128(), rnd128(), 1'b0, 1'($urandom), '0, 1'b0);

        for (int i = 0; i < 5; i++)
            drive(rnd128(), rnd128(), 1'b0, 1'b1, '0, 1'b0);
        drive(rnd128(), rnd128(), 1'b1, 1'b1, '0, 1'b0);

        for (int i = 0; i < 30; i++)
            drive(rnd128(), rnd128(), 1'b0, 1'($urandom), '0, 1'b0);
        for (int i = 0; i < 22; i++)
            drive(rnd128(), rnd128(), 1'b0, 1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
